// File: rtl/bmu_chain_ctrl.sv
// Sequencer for the three-stage branch-metric chain: packs a symbol stream into triples,
// holds each triple until the chain answers, and pulses refresh on frame end, timeout or flush.
module bmu_chain_ctrl #(
  parameter int FRAME_LEN = 8,
  parameter int TIMEOUT   = 15,
  parameter int PIPE_LAT  = 3,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       sym_in,
  input  logic             sym_valid,
  output logic             sym_ready,
  input  logic             flush,
  input  logic             chain_valid,
  output logic [1:0]       bit_pair_0,
  output logic [1:0]       bit_pair_1,
  output logic [1:0]       bit_pair_2,
  output logic             refresh,
  output logic             win_done,
  output logic [CNT_W-1:0] window_idx,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             err_timeout
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MIN = WAIT_W'(PIPE_LAT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  LAST_WIN = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        fill_q, fill_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]        bp0_q, bp0_d;
  logic [1:0]        bp1_q, bp1_d;
  logic [1:0]        bp2_q, bp2_d;
  logic              sym_ready_q, sym_ready_d;
  logic              refresh_q, refresh_d;
  logic              win_done_q, win_done_d;
  logic              frame_done_q, frame_done_d;
  logic [CNT_W-1:0]  window_idx_q, window_idx_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              err_timeout_q, err_timeout_d;
  logic              refresh_req;
  logic              hs;

  assign hs = sym_valid && sym_ready_q;

  always_comb begin
    // NOTE: every _d takes its hold value before the case so no path leaves it unassigned (no latch).
    state_d       = state_q;
    fill_d        = fill_q;
    wait_cnt_d    = wait_cnt_q;
    bp0_d         = bp0_q;
    bp1_d         = bp1_q;
    bp2_d         = bp2_q;
    sym_ready_d   = sym_ready_q;
    refresh_req   = 1'b0;
    win_done_d    = 1'b0;
    frame_done_d  = 1'b0;
    window_idx_d  = window_idx_q;
    frame_cnt_d   = frame_cnt_q;
    err_timeout_d = err_timeout_q;

    case (state_q)
      S_IDLE: begin
        sym_ready_d = 1'b1;
        if (hs) begin
          bp0_d   = sym_in;
          fill_d  = 2'd1;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        sym_ready_d = 1'b1;
        if (hs) begin
          if (fill_q == 2'd1) begin
            bp1_d  = sym_in;
            fill_d = 2'd2;
          end else begin
            bp2_d       = sym_in;
            fill_d      = 2'd0;
            wait_cnt_d  = '0;
            sym_ready_d = 1'b0;
            state_d     = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        sym_ready_d = 1'b0;
        // Early chain_valid belongs to the previous triple still draining out of the pipe.
        if (chain_valid && (wait_cnt_q >= WAIT_MIN)) begin
          state_d = S_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_d == WAIT_MAX) begin
            err_timeout_d = 1'b1;
            refresh_req   = 1'b1;
            window_idx_d  = '0;
            sym_ready_d   = 1'b1;
            state_d       = S_IDLE;
          end
        end
      end

      S_DONE: begin
        win_done_d  = 1'b1;
        sym_ready_d = 1'b1;
        state_d     = S_IDLE;
        if (window_idx_q == LAST_WIN) begin
          refresh_req  = 1'b1;
          frame_done_d = 1'b1;
          window_idx_d = '0;
          frame_cnt_d  = frame_cnt_q + 1'b1;
        end else begin
          window_idx_d = window_idx_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Flush overrides every transition but still lets a completing DONE be reported.
    if (flush) begin
      state_d       = S_IDLE;
      fill_d        = 2'd0;
      wait_cnt_d    = '0;
      bp0_d         = bp0_q;
      bp1_d         = bp1_q;
      bp2_d         = bp2_q;
      sym_ready_d   = 1'b0;
      window_idx_d  = '0;
      err_timeout_d = err_timeout_q;
      refresh_req   = 1'b1;
    end
  end

  // A refresh is never stretched: a request right after a pulse is dropped for one cycle.
  assign refresh_d = refresh_req && !refresh_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      fill_q        <= 2'd0;
      wait_cnt_q    <= '0;
      bp0_q         <= 2'b00;
      bp1_q         <= 2'b00;
      bp2_q         <= 2'b00;
      sym_ready_q   <= 1'b0;
      refresh_q     <= 1'b0;
      win_done_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      window_idx_q  <= '0;
      frame_cnt_q   <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fill_q        <= fill_d;
      wait_cnt_q    <= wait_cnt_d;
      bp0_q         <= bp0_d;
      bp1_q         <= bp1_d;
      bp2_q         <= bp2_d;
      sym_ready_q   <= sym_ready_d;
      refresh_q     <= refresh_d;
      win_done_q    <= win_done_d;
      frame_done_q  <= frame_done_d;
      window_idx_q  <= window_idx_d;
      frame_cnt_q   <= frame_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign sym_ready   = sym_ready_q;
  assign bit_pair_0  = bp0_q;
  assign bit_pair_1  = bp1_q;
  assign bit_pair_2  = bp2_q;
  assign refresh     = refresh_q;
  assign win_done    = win_done_q;
  assign window_idx  = window_idx_q;
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_timeout = err_timeout_q;

endmodule
